control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired Moore control unit for the single-bus CPU datapath. Replaces hand-driven testbench
//  stimulus: runs fetch (T0-T2), decodes IR[31:27], then issues per-step datapath control signals
//  for each supported instruction. Sits beside the datapath; its outputs connect 1:1 to the datapath ports.
// PARAMETERS
//  OPW     5  opcode width (IR[31:27])
//  ALUW    5  width of alu_op function code
// PORTS
//  clock      in   1  datapath clock; all state changes on rising edge
//  clear      in   1  synchronous, active-high reset
//  run        in   1  level; 1 = start/continue issuing instructions
//  opcode     in   OPW  IR[31:27]; read only at T3 and later
//  con_ff     in   1  datapath CON flip-flop; read only at BR_T6
//  PCout,PCin,IncPC,MARin,MDRin,MDRout,Read,Write,IRin   out 1 each  datapath strobes
//  Yin,ZLowIn,ZHighIn,ZLowOut,ZHighOut,Gra,Grb,Grc,Rin,Rout,BAout,RCout,HIin,LOin,CONin  out 1 each
//  alu_op     out  ALUW  ALU function select; valid while ZLowIn=1, else 0
//  instr_done out  1  1-cycle pulse in the last step of each instruction
//  halted     out  1  1 while in HALT
//  illegal    out  1  sticky; unknown opcode decoded
// BEHAVIOUR
//  Moore: every output is decoded from the state register only. IDLE/HALT drive all strobes 0.
//  Reset: on a clock edge with clear=1 the state becomes IDLE; all outputs are 0 from the next cycle,
//   illegal is cleared. Mid-instruction reset aborts the instruction; no partial step repeats.
//  IDLE->T0 when run=1. At the final step of an instruction: next = T0 if run=1, else IDLE.
//  Fetch: T0 PCout,MARin,IncPC | T1 Read,MDRin | T2 MDRout,IRin | T3 = first execute step.
//  Opcodes / execute steps (one cycle per '|'):
//   add 00011 / sub 00100 / and 00101 / or 00110: Grb,Rout,Yin | Grc,Rout,ZLowIn,alu_op=opcode | ZLowOut,Gra,Rin
//   addi 01100: Grb,Rout,Yin | RCout,ZLowIn,alu_op=ADD(00011) | ZLowOut,Gra,Rin
//   ldi 00001: Grb,BAout,Yin | RCout,ZLowIn,alu_op=ADD | ZLowOut,Gra,Rin
//   ld 00000: Grb,BAout,Yin | RCout,ZLowIn,ADD | ZLowOut,MARin | Read,MDRin | MDRout,Gra,Rin
//   st 00010: Grb,BAout,Yin | RCout,ZLowIn,ADD | ZLowOut,MARin | Gra,Rout,MDRin (Read=0) | Write
//   br 10010: Gra,Rout,CONin | PCout,Yin | RCout,ZLowIn,ADD | BR_T6: ZLowOut, PCin=con_ff
//   jr 10100: Gra,Rout,PCin
//   nop 11010: single T3 step, no strobes, instr_done=1
//   halt 11011: enter HALT; stay until clear (run ignored); halted=1
//   any other opcode: illegal<=1, enter HALT.
//  BR: con_ff is sampled combinationally in BR_T6 only (CON latched at end of first br step, so it is stable).
//   Not taken: PCin=0 in BR_T6, PC keeps fetch-incremented value.
//  At most one bus driver (PCout,MDRout,ZLowOut,ZHighOut,Rout,RCout) asserted in any state.
//  Write and Read never asserted together; Write asserted only in ST last step.
//  ZHighIn, ZHighOut, HIin, LOin reserved for mul/div: held 0 in this version.
//  run dropped mid-instruction: instruction completes, then IDLE; run toggles never skip a step.
//  Latency: fetch 3 cycles; total nop 4, jr 4, alu/addi/ldi 6, br 7, ld/st 8 cycles.
// TESTING
//  1 clear=1 two cycles then run=1 -> T0 next cycle: PCout=MARin=IncPC=1; all outputs 0 during IDLE.
//  2 IR=add R1,R2,R3 (opcode 00011) -> cycles T3..T5: Grb/Rout/Yin, Grc/Rout/ZLowIn alu_op=00011,
//     ZLowOut/Gra/Rin; instr_done high in T5 only; T0 follows at cycle 7 with run=1.
//  3 ld R1,0x55(R0) then st 0x55(R0),R1 -> ld 8 cycles with Read/MDRin in step 7; st Write=1 only in
//     cycle 8; Read=0 throughout st execute.
//  4 br, con_ff=1 -> PCin=1 with ZLowOut in cycle 7; repeat con_ff=0 -> PCin=0, next fetch PCout = old PC+1.
//  5 opcode 11011 -> halted=1 indefinitely with run=1; opcode 11111 -> illegal=1, halted=1; clear -> both 0, IDLE.
//  6 clear asserted during ld step 6 -> next cycle IDLE, all strobes 0, no Write/Read; run=1 restarts at T0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired control sequencer and the single-bus
// CPU datapath.
//   master : sequencer side. It takes run/opcode/con_ff and drives every
//            datapath strobe plus alu_op, instr_done, halted and illegal.
//   slave  : datapath/stimulus side, with the opposite directions.
// Parameters: OPW is the opcode width (IR[31:27]); ALUW is the alu_op width.
interface control_sequencer_if #(
  parameter int OPW  = 5,
  parameter int ALUW = 5
);
  logic            run;
  logic [OPW-1:0]  opcode;
  logic            con_ff;

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
  logic Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut, Gra, Grb, Grc, Rin, Rout;
  logic BAout, RCout, HIin, LOin, CONin;
  logic [ALUW-1:0] alu_op;
  logic            instr_done;
  logic            halted;
  logic            illegal;

  modport master (
    input  run, opcode, con_ff,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
           Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut, Gra, Grb, Grc, Rin, Rout,
           BAout, RCout, HIin, LOin, CONin, alu_op, instr_done, halted, illegal
  );

  modport slave (
    output run, opcode, con_ff,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
           Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut, Gra, Grb, Grc, Rin, Rout,
           BAout, RCout, HIin, LOin, CONin, alu_op, instr_done, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus CPU datapath.
// The unit runs fetch (T0-T2), decodes the opcode (IR[31:27]) in T3, and then
// steps through the execute states of add/sub/and/or/addi/ldi/ld/st/br/jr/
// nop/halt. An unknown opcode sets the sticky illegal flag and enters HALT.
// Ports:
//   clock : rising-edge clock
//   clear : synchronous active-high reset; the state returns to IDLE
//   bus   : control_sequencer_if.master (run, opcode, con_ff in; strobes out)
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input logic                clock,
  input logic                clear,
  control_sequencer_if.master bus
);

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(5'b00011);

  typedef enum logic [4:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_ALU_T4, S_ALU_T5,
    S_IMM_T4, S_MEM_T5,
    S_LD_T6, S_LD_T7,
    S_ST_T6, S_ST_T7,
    S_BR_T4, S_BR_T5, S_BR_T6,
    S_HALT
  } state_t;

  typedef struct packed {
    logic            pc_out;
    logic            pc_in;
    logic            inc_pc;
    logic            mar_in;
    logic            mdr_in;
    logic            mdr_out;
    logic            rd;
    logic            wr;
    logic            ir_in;
    logic            y_in;
    logic            zlo_in;
    logic            zlo_out;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            r_in;
    logic            r_out;
    logic            ba_out;
    logic            rc_out;
    logic            con_in;
    logic            done;
    logic [ALUW-1:0] alu;
  } strobe_t;

  state_t  state;
  state_t  nxt;
  strobe_t strobe_q;
  strobe_t t3_strobes;
  strobe_t strobe;
  logic    halted_q;
  logic    illegal_q;

  function automatic logic is_alu(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_known(input logic [OPW-1:0] op);
    return is_alu(op) || (op == OP_ADDI) || (op == OP_LDI) || (op == OP_LD) ||
           (op == OP_ST) || (op == OP_BR) || (op == OP_JR) || (op == OP_NOP) ||
           (op == OP_HALT);
  endfunction

  // Strobe pattern for each state. Only T3 and ALU_T4 look at the opcode,
  // which is a register in the datapath, so the decode is glitch-free.
  function automatic strobe_t state_strobes(input state_t s, input logic [OPW-1:0] op);
    strobe_t st;
    st = '0;
    case (s)
      S_T0: begin st.pc_out = 1'b1; st.mar_in = 1'b1; st.inc_pc = 1'b1; end
      S_T1: begin st.rd = 1'b1; st.mdr_in = 1'b1; end
      S_T2: begin st.mdr_out = 1'b1; st.ir_in = 1'b1; end
      S_T3: begin
        if (is_alu(op) || op == OP_ADDI) begin
          st.grb = 1'b1; st.r_out = 1'b1; st.y_in = 1'b1;
        end else if (op == OP_LDI || op == OP_LD || op == OP_ST) begin
          st.grb = 1'b1; st.ba_out = 1'b1; st.y_in = 1'b1;
        end else if (op == OP_BR) begin
          st.gra = 1'b1; st.r_out = 1'b1; st.con_in = 1'b1;
        end else if (op == OP_JR) begin
          st.gra = 1'b1; st.r_out = 1'b1; st.pc_in = 1'b1; st.done = 1'b1;
        end else if (op == OP_NOP) begin
          st.done = 1'b1;
        end
      end
      S_ALU_T4: begin
        st.grc = 1'b1; st.r_out = 1'b1; st.zlo_in = 1'b1; st.alu = ALUW'(op);
      end
      S_IMM_T4, S_BR_T5: begin
        st.rc_out = 1'b1; st.zlo_in = 1'b1; st.alu = ALU_ADD;
      end
      S_ALU_T5: begin st.zlo_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1; st.done = 1'b1; end
      S_MEM_T5: begin st.zlo_out = 1'b1; st.mar_in = 1'b1; end
      S_LD_T6:  begin st.rd = 1'b1; st.mdr_in = 1'b1; end
      S_LD_T7:  begin st.mdr_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1; st.done = 1'b1; end
      S_ST_T6:  begin st.gra = 1'b1; st.r_out = 1'b1; st.mdr_in = 1'b1; end
      S_ST_T7:  begin st.wr = 1'b1; st.done = 1'b1; end
      S_BR_T4:  begin st.pc_out = 1'b1; st.y_in = 1'b1; end
      S_BR_T6:  begin st.zlo_out = 1'b1; st.done = 1'b1; end
      default:  st = '0;
    endcase
    return st;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = bus.run ? S_T0 : S_IDLE;
      S_T0:   nxt = S_T1;
      S_T1:   nxt = S_T2;
      S_T2:   nxt = S_T3;
      S_T3: begin
        if (is_alu(bus.opcode))
          nxt = S_ALU_T4;
        else if (bus.opcode == OP_ADDI || bus.opcode == OP_LDI ||
                 bus.opcode == OP_LD   || bus.opcode == OP_ST)
          nxt = S_IMM_T4;
        else if (bus.opcode == OP_BR)
          nxt = S_BR_T4;
        else if (bus.opcode == OP_JR || bus.opcode == OP_NOP)
          nxt = bus.run ? S_T0 : S_IDLE;
        else
          nxt = S_HALT;
      end
      S_ALU_T4: nxt = S_ALU_T5;
      S_IMM_T4: nxt = (bus.opcode == OP_ADDI || bus.opcode == OP_LDI) ? S_ALU_T5 : S_MEM_T5;
      S_MEM_T5: nxt = (bus.opcode == OP_LD) ? S_LD_T6 : S_ST_T6;
      S_LD_T6:  nxt = S_LD_T7;
      S_ST_T6:  nxt = S_ST_T7;
      S_BR_T4:  nxt = S_BR_T5;
      S_BR_T5:  nxt = S_BR_T6;
      S_ALU_T5, S_LD_T7, S_ST_T7, S_BR_T6: nxt = bus.run ? S_T0 : S_IDLE;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  // The strobes of the next state are registered alongside the state. The
  // exception is T3: IR is only loaded at the end of T2, so the T3 pattern is
  // not known a cycle early. It is decoded from the state register and the
  // opcode instead.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= S_IDLE;
      strobe_q  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state    <= nxt;
      strobe_q <= (nxt == S_T3) ? '0 : state_strobes(nxt, bus.opcode);
      halted_q <= (nxt == S_HALT);
      if (state == S_T3 && !is_known(bus.opcode))
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    t3_strobes = '0;
    if (state == S_T3)
      t3_strobes = state_strobes(S_T3, bus.opcode);
  end

  assign strobe = strobe_q | t3_strobes;

  assign bus.PCout  = strobe.pc_out;
  // CON was latched at the end of the first br step, so con_ff is stable here.
  assign bus.PCin   = strobe.pc_in | ((state == S_BR_T6) & bus.con_ff);
  assign bus.IncPC  = strobe.inc_pc;
  assign bus.MARin  = strobe.mar_in;
  assign bus.MDRin  = strobe.mdr_in;
  assign bus.MDRout = strobe.mdr_out;
  assign bus.Read   = strobe.rd;
  assign bus.Write  = strobe.wr;
  assign bus.IRin   = strobe.ir_in;
  assign bus.Yin    = strobe.y_in;
  assign bus.ZLowIn = strobe.zlo_in;
  assign bus.ZLowOut = strobe.zlo_out;
  assign bus.Gra    = strobe.gra;
  assign bus.Grb    = strobe.grb;
  assign bus.Grc    = strobe.grc;
  assign bus.Rin    = strobe.r_in;
  assign bus.Rout   = strobe.r_out;
  assign bus.BAout  = strobe.ba_out;
  assign bus.RCout  = strobe.rc_out;
  assign bus.CONin  = strobe.con_in;
  assign bus.alu_op = strobe.alu;
  assign bus.instr_done = strobe.done;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;

  // These strobes are reserved for mul/div and are not used by this instruction set.
  assign bus.ZHighIn  = 1'b0;
  assign bus.ZHighOut = 1'b0;
  assign bus.HIin     = 1'b0;
  assign bus.LOin     = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [31:0] E_PCOUT   = 32'h1 << 31;
  localparam logic [31:0] E_PCIN    = 32'h1 << 30;
  localparam logic [31:0] E_INCPC   = 32'h1 << 29;
  localparam logic [31:0] E_MARIN   = 32'h1 << 28;
  localparam logic [31:0] E_MDRIN   = 32'h1 << 27;
  localparam logic [31:0] E_MDROUT  = 32'h1 << 26;
  localparam logic [31:0] E_READ    = 32'h1 << 25;
  localparam logic [31:0] E_WRITE   = 32'h1 << 24;
  localparam logic [31:0] E_IRIN    = 32'h1 << 23;
  localparam logic [31:0] E_YIN     = 32'h1 << 22;
  localparam logic [31:0] E_ZLIN    = 32'h1 << 21;
  localparam logic [31:0] E_ZLOUT   = 32'h1 << 19;
  localparam logic [31:0] E_GRA     = 32'h1 << 17;
  localparam logic [31:0] E_GRB     = 32'h1 << 16;
  localparam logic [31:0] E_GRC     = 32'h1 << 15;
  localparam logic [31:0] E_RIN     = 32'h1 << 14;
  localparam logic [31:0] E_ROUT    = 32'h1 << 13;
  localparam logic [31:0] E_BAOUT   = 32'h1 << 12;
  localparam logic [31:0] E_RCOUT   = 32'h1 << 11;
  localparam logic [31:0] E_CONIN   = 32'h1 << 8;
  localparam logic [31:0] E_DONE    = 32'h1 << 7;
  localparam logic [31:0] E_HALTED  = 32'h1 << 6;
  localparam logic [31:0] E_ILLEGAL = 32'h1 << 5;

  localparam logic [31:0] E_T0 = E_PCOUT | E_MARIN | E_INCPC;
  localparam logic [31:0] E_T1 = E_READ | E_MDRIN;
  localparam logic [31:0] E_T2 = E_MDROUT | E_IRIN;

  typedef struct {
    logic [31:0] v;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] actual;

  control_sequencer_if #(.OPW(5), .ALUW(5)) bus ();

  control_sequencer #(.OPW(5), .ALUW(5)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  assign actual = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                   bus.Read, bus.Write, bus.IRin, bus.Yin, bus.ZLowIn, bus.ZHighIn,
                   bus.ZLowOut, bus.ZHighOut, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                   bus.Rout, bus.BAout, bus.RCout, bus.HIin, bus.LOin, bus.CONin,
                   bus.instr_done, bus.halted, bus.illegal, bus.alu_op};

  // Monitor: checks one expected output vector per cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (actual !== e.v) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, actual, e.v);
        end
      end
    end
  end

  // Wait for the next rising edge, then queue the outputs required for that cycle.
  task automatic step(input logic [31:0] v, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    e.v = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // The opcode changes only once T0 has begun, so the previous instruction's
  // last step never sees the new opcode.
  task automatic fetch(input logic [4:0] op, input logic c);
    step(E_T0, "fetch_t0");
    bus.opcode = op;
    bus.con_ff = c;
    step(E_T1, "fetch_t1");
    step(E_T2, "fetch_t2");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    clear = 1'b1;
    bus.run = 1'b0;
    bus.con_ff = 1'b0;
    bus.opcode = 5'b11010;
    step('0, "reset0");
    step('0, "reset1");
    clear = 1'b0;
    step('0, "idle");
    bus.run = 1'b1;

    fetch(5'b00011, 1'b0);
    step(E_GRB | E_ROUT | E_YIN, "add_t3");
    step(E_GRC | E_ROUT | E_ZLIN | 32'd3, "add_t4");
    step(E_ZLOUT | E_GRA | E_RIN | E_DONE, "add_t5");

    fetch(5'b00000, 1'b0);
    step(E_GRB | E_BAOUT | E_YIN, "ld_t3");
    step(E_RCOUT | E_ZLIN | 32'd3, "ld_t4");
    step(E_ZLOUT | E_MARIN, "ld_t5");
    step(E_READ | E_MDRIN, "ld_t6");
    step(E_MDROUT | E_GRA | E_RIN | E_DONE, "ld_t7");

    fetch(5'b00010, 1'b0);
    step(E_GRB | E_BAOUT | E_YIN, "st_t3");
    step(E_RCOUT | E_ZLIN | 32'd3, "st_t4");
    step(E_ZLOUT | E_MARIN, "st_t5");
    step(E_GRA | E_ROUT | E_MDRIN, "st_t6");
    step(E_WRITE | E_DONE, "st_t7");

    fetch(5'b00100, 1'b0);
    step(E_GRB | E_ROUT | E_YIN, "sub_t3");
    step(E_GRC | E_ROUT | E_ZLIN | 32'd4, "sub_t4");
    step(E_ZLOUT | E_GRA | E_RIN | E_DONE, "sub_t5");

    fetch(5'b00110, 1'b0);
    step(E_GRB | E_ROUT | E_YIN, "or_t3");
    step(E_GRC | E_ROUT | E_ZLIN | 32'd6, "or_t4");
    step(E_ZLOUT | E_GRA | E_RIN | E_DONE, "or_t5");

    fetch(5'b01100, 1'b0);
    step(E_GRB | E_ROUT | E_YIN, "addi_t3");
    step(E_RCOUT | E_ZLIN | 32'd3, "addi_t4");
    step(E_ZLOUT | E_GRA | E_RIN | E_DONE, "addi_t5");

    fetch(5'b00001, 1'b0);
    step(E_GRB | E_BAOUT | E_YIN, "ldi_t3");
    step(E_RCOUT | E_ZLIN | 32'd3, "ldi_t4");
    step(E_ZLOUT | E_GRA | E_RIN | E_DONE, "ldi_t5");

    fetch(5'b10010, 1'b1);
    step(E_GRA | E_ROUT | E_CONIN, "br1_t3");
    step(E_PCOUT | E_YIN, "br1_t4");
    step(E_RCOUT | E_ZLIN | 32'd3, "br1_t5");
    step(E_ZLOUT | E_PCIN | E_DONE, "br1_t6_taken");

    fetch(5'b10010, 1'b0);
    step(E_GRA | E_ROUT | E_CONIN, "br0_t3");
    step(E_PCOUT | E_YIN, "br0_t4");
    step(E_RCOUT | E_ZLIN | 32'd3, "br0_t5");
    step(E_ZLOUT | E_DONE, "br0_t6_not_taken");

    fetch(5'b10100, 1'b0);
    step(E_GRA | E_ROUT | E_PCIN | E_DONE, "jr_t3");

    fetch(5'b11010, 1'b0);
    step(E_DONE, "nop_t3");

    // run dropped mid-instruction: the instruction completes, then IDLE
    fetch(5'b00101, 1'b0);
    step(E_GRB | E_ROUT | E_YIN, "and_t3");
    step(E_GRC | E_ROUT | E_ZLIN | 32'd5, "and_t4");
    bus.run = 1'b0;
    step(E_ZLOUT | E_GRA | E_RIN | E_DONE, "and_t5");
    step('0, "idle_after_drop0");
    step('0, "idle_after_drop1");
    bus.run = 1'b1;

    // clear during ld step 6 aborts the instruction
    fetch(5'b00000, 1'b0);
    step(E_GRB | E_BAOUT | E_YIN, "ldc_t3");
    step(E_RCOUT | E_ZLIN | 32'd3, "ldc_t4");
    step(E_ZLOUT | E_MARIN, "ldc_t5");
    clear = 1'b1;
    step('0, "clr_mid_ld");
    clear = 1'b0;
    fetch(5'b11010, 1'b0);
    step(E_DONE, "nop_after_clr");

    // halt: stays halted while run=1 until clear
    fetch(5'b11011, 1'b0);
    step('0, "halt_t3");
    step(E_HALTED, "halted0");
    step(E_HALTED, "halted1");
    step(E_HALTED, "halted2");
    clear = 1'b1;
    bus.run = 1'b0;
    step('0, "halt_clear");
    clear = 1'b0;
    step('0, "idle_after_halt");
    bus.run = 1'b1;

    // unknown opcode: sticky illegal plus halt
    fetch(5'b11111, 1'b0);
    step('0, "ill_t3");
    step(E_HALTED | E_ILLEGAL, "illegal0");
    step(E_HALTED | E_ILLEGAL, "illegal1");
    clear = 1'b1;
    bus.run = 1'b0;
    step('0, "illegal_clear");
    clear = 1'b0;
    step('0, "idle_after_illegal0");
    step('0, "idle_after_illegal1");

    repeat (3) @(posedge clock);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
